// File: rtl/layer_pipe_stage_pkg.sv
// Shared packing constants for the LogicNets layer boundaries and LUT banks.
// Every stage and LUT bank derives its vector width from here so packing agrees.
package layer_pipe_stage_pkg;

  localparam int unsigned ACT_BITS   = 2;
  localparam int unsigned L0_NEURONS = 64;
  localparam int unsigned L1_NEURONS = 32;

  function automatic int unsigned packed_width(input int unsigned neurons);
    return neurons * ACT_BITS;
  endfunction

  localparam int unsigned L0_DATA_W = L0_NEURONS * ACT_BITS;
  localparam int unsigned L1_DATA_W = L1_NEURONS * ACT_BITS;

endpackage

// File: rtl/layer_pipe_stage_if.sv
// Valid/ready vector bus between a neuron LUT bank and a layer pipe stage.
interface layer_pipe_stage_if #(
  parameter int unsigned DATA_W = layer_pipe_stage_pkg::L0_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/layer_pipe_stage.sv
// Two-entry skid buffer between layer-0 and layer-1 LUT banks, with a
// registered upstream ready and a saturating stall counter.
module layer_pipe_stage
  import layer_pipe_stage_pkg::*;
#(
  parameter int unsigned NEURONS  = layer_pipe_stage_pkg::L0_NEURONS,
  parameter int unsigned ACT_BITS = layer_pipe_stage_pkg::ACT_BITS,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layer_pipe_stage_if.slave    s_if,
  layer_pipe_stage_if.master   m_if,
  input  logic                 flush,
  input  logic                 stat_clr,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);
  localparam int unsigned DATA_W = NEURONS * ACT_BITS;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              s_ready_q,    s_ready_d;
  logic [1:0]        occupancy_q,  occupancy_d;
  logic              accept, drain;

  // ready is a flop; flush only masks it so no accept can be counted
  assign accept = s_if.valid & s_ready_q & ~flush;
  assign drain  = main_valid_q & m_if.ready & ~flush;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (drain && accept) begin
        main_data_d = s_if.data;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        skid_data_d  = s_if.data;
        skid_valid_d = 1'b1;
      end
    end else if (accept) begin
      main_data_d  = s_if.data;
      main_valid_d = 1'b1;
    end
    s_ready_d   = ~skid_valid_d;
    occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      s_ready_q    <= 1'b1;
      occupancy_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      s_ready_q    <= s_ready_d;
      occupancy_q  <= occupancy_d;
    end
  end

  assign s_if.ready = s_ready_q & ~flush;
  assign m_if.valid = main_valid_q;
  assign m_if.data  = main_data_q;
  assign occupancy  = occupancy_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_valid_q & ~m_if.ready),
    .clr   (stat_clr),
    .count (stall_cnt)
  );
endmodule

// File: tb/tb_layer_pipe_stage.sv
// Bench for layer_pipe_stage: directed and random traffic against a queue model.
module tb_layer_pipe_stage;
  import layer_pipe_stage_pkg::*;

  localparam int unsigned DW = L0_DATA_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          stat_clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [1:0]    occ, occ4;
  logic [15:0]   stall;
  logic [3:0]    stall4;

  always #5 clk = ~clk;

  layer_pipe_stage_if #(.DATA_W(DW)) s_if ();
  layer_pipe_stage_if #(.DATA_W(DW)) m_if ();
  layer_pipe_stage_if #(.DATA_W(DW)) s4_if ();
  layer_pipe_stage_if #(.DATA_W(DW)) m4_if ();

  assign s_if.valid  = s_valid;
  assign s_if.data   = s_data;
  assign m_if.ready  = m_ready;
  assign s4_if.valid = s_valid;
  assign s4_if.data  = s_data;
  assign m4_if.ready = m_ready;

  layer_pipe_stage #(.NEURONS(L0_NEURONS), .ACT_BITS(ACT_BITS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(s_if), .m_if(m_if),
    .flush(flush), .stat_clr(stat_clr), .occupancy(occ), .stall_cnt(stall)
  );

  layer_pipe_stage #(.NEURONS(L0_NEURONS), .ACT_BITS(ACT_BITS), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_if(s4_if), .m_if(m4_if),
    .flush(flush), .stat_clr(stat_clr), .occupancy(occ4), .stall_cnt(stall4)
  );

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] q[$];
  int unsigned   stall_ev = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rvec();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    stall_ev = 0;
  endtask

  // Behavioural view: an ordered store of at most two vectors
  task automatic model_step();
    int unsigned sz;
    bit drain, acc;
    sz = q.size();
    if (stat_clr) stall_ev = 0;
    else if (sz > 0 && !m_ready) stall_ev++;
    if (flush) begin
      q.delete();
    end else begin
      drain = (sz > 0) && m_ready;
      acc   = s_valid && (sz < 2);
      if (drain) void'(q.pop_front());
      if (acc) q.push_back(s_data);
    end
  endtask

  task automatic check_all();
    int unsigned e16, e4;
    e16 = (stall_ev > 65535) ? 65535 : stall_ev;
    e4  = (stall_ev > 15) ? 15 : stall_ev;
    chk("m_valid", DW'(m_if.valid), DW'(q.size() > 0));
    if (q.size() > 0) chk("m_data", m_if.data, q[0]);
    chk("s_ready", DW'(s_if.ready), DW'((q.size() < 2) && !flush));
    chk("occupancy", DW'(occ), DW'(q.size()));
    chk("stall_cnt", DW'(stall), DW'(e16));
    chk("stall_cnt_w4", DW'(stall4), DW'(e4));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int unsigned idx;
    logic [DW-1:0] v[3];

    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("reset_m_data", m_if.data, '0);
    #15 rst_n = 1'b1;

    // first vector after reset: 1-cycle latency
    s_data = rvec();
    s_data[7:0] = 8'hA5;
    s_valid = 1'b1;
    m_ready = 1'b1;
    cycle();
    chk("first_m_data", m_if.data, s_data);
    s_valid = 1'b0;
    cycle();

    // back-to-back stream with ready held high
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(1000 + i);
      cycle();
    end
    s_valid = 1'b0;
    cycle();
    cycle();

    // backpressure: three offered, two held, then drained in order
    for (int k = 0; k < 3; k++) v[k] = rvec();
    m_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1;
      s_data  = v[idx];
      if (q.size() < 2 && idx < 2) begin
        cycle();
        idx++;
      end else begin
        cycle();
      end
    end
    m_ready = 1'b1;
    s_data  = v[2];
    for (int c = 0; c < 4; c++) begin
      s_valid = (c < 2);
      cycle();
    end

    // flush with both entries held and upstream still offering
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = rvec();
    cycle();
    s_data  = rvec();
    cycle();
    flush   = 1'b1;
    s_data  = rvec();
    #1;
    chk("flush_s_ready", DW'(s_if.ready), '0);
    cycle();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    // long stall saturates the narrow counter; clear wins over a stall
    s_valid = 1'b1;
    s_data  = rvec();
    cycle();
    s_valid = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) cycle();
    chk("sat_w4", DW'(stall4), DW'(15));
    stat_clr = 1'b1;
    cycle();
    chk("clr_stall", DW'(stall), '0);
    stat_clr = 1'b0;

    // async reset between edges with both entries occupied
    s_valid = 1'b1;
    s_data  = rvec();
    cycle();
    s_valid = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_m_data", m_if.data, '0);
    #2 rst_n = 1'b1;

    // random traffic
    for (int c = 0; c < 400; c++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      stat_clr = ($urandom_range(0, 31) == 0);
      s_data   = rvec();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_pipe_stage.md
# layer_pipe_stage

Registered valid/ready boundary between the layer-0 neuron LUT bank and the layer-1 neuron LUT bank of the sparse LogicNets classifier. It captures the packed 2-bit activations of every layer-0 neuron and holds them in a two-entry skid buffer. It presents a stable vector to the purely combinational layer-1 LUTs, whose 6-bit inputs are fixed sparse slices of that vector. The block breaks the combinational path between layers, sustains one vector per cycle under backpressure, and counts stall cycles for throughput debug.

## Interface
- NEURONS, 64, number of layer-0 neurons feeding this stage
- ACT_BITS, 2, activation width per neuron; must equal the LUT output width
- DATA_W, NEURONS*ACT_BITS, packed vector width; derived, not overridden
- CNT_W, 16, stall counter width
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  upstream vector valid
- s_ready  out  1  stage can accept; registered
- s_data  in  DATA_W  packed activations; neuron i at bits [i*ACT_BITS +: ACT_BITS]
- m_valid  out  1  vector presented to layer-1 LUTs
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  registered vector, same packing as s_data
- flush  in  1  synchronous discard of all held vectors
- stat_clr  in  1  synchronous clear of stall_cnt
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0, saturating

## Operation
- Two entries: main, which drives m_data/m_valid, and skid.
- s_ready = !skid_valid. It is a register output with no combinational path from m_ready.
- Accept = s_valid & s_ready. Drain = m_valid & m_ready.
- Empty, accept: data goes to main, and m_valid rises next cycle.
- Main full, drain and accept in the same cycle: main takes s_data. No bubble.
- Main full, no drain, accept: data goes to skid, skid_valid=1, and s_ready falls next cycle.
- Skid full, drain: main takes skid, skid empties, and s_ready rises next cycle.
- Skid full, no drain: all state holds. s_ready=0.
- Data in a held entry never changes while its valid bit is set and it is not drained.
- flush=1 clears main_valid and skid_valid next cycle and overrides accept and drain. While flush=1, s_ready is driven 0 combinationally (AND with !flush) so no accept is counted. m_data value after flush is don't-care, but it is reset to 0.
- occupancy = main_valid + skid_valid, registered with the entries.
- stall_cnt increments when m_valid & !m_ready, saturates at 2^CNT_W-1, and is cleared by stat_clr (priority over increment). flush does not clear it.
- Ordering is strictly FIFO. No vector is duplicated or dropped except by flush.

## Timing
- Reset values: m_valid=0, s_ready=1, m_data=0, occupancy=0, stall_cnt=0, skid data=0.
- Reset mid-operation clears everything immediately and asynchronously. The first accept is possible on the first clock edge after rst_n deasserts.
- Latency s_data to m_data is 1 cycle when empty. Sustained throughput is 1 vector/cycle with m_ready held high.
- m_valid, once high, stays high with stable m_data until drained or flushed.
- After m_ready deasserts, at most one further vector is accepted, into skid.

## Structure
- Shared package holds ACT_BITS, the per-layer NEURONS constants and the derived DATA_W, so every layer boundary and LUT bank agree on packing.
- One natural sub-module: `sat_counter` (CNT_W, inc, clr, count), reused by the other layer stages for stall statistics.
- Entry logic stays inline. There is no generic FIFO: the depth is fixed at 2.

## Test plan
- Reset release, then s_valid=1 with s_data=0x…A5 and m_ready=1 → m_valid=1 and m_data=0x…A5 one cycle later. occupancy=1. stall_cnt=0.
- Stream of 100 incrementing vectors with m_ready=1 → 100 outputs in order, no bubbles after the first, and s_ready never low.
- m_ready=0 while 3 vectors are offered → the first 2 are accepted, s_ready=0, occupancy=2, and stall_cnt rises by 1 per cycle. Release m_ready → outputs come in order V0, V1, then V2, with s_ready high again one cycle after the first drain.
- flush asserted with occupancy=2 and s_valid=1 → next cycle m_valid=0 and occupancy=0, s_ready was 0 during flush, and no flushed vector ever appears.
- CNT_W=4 with a held stall of 20 cycles → stall_cnt saturates at 15. stat_clr together with a stall → 0 next cycle.
- Asynchronous rst_n pulse between clock edges with occupancy=2 → outputs reach reset values immediately, and the stream resumes correctly afterwards.
